// File: rtl/pcie_noc_downsizer.sv
// Receive-side width converter: wide PCIe endpoint words in, narrow BlueNoC beats out,
// least-significant lane first, with debug beat/message counters.
module pcie_noc_downsizer #(
  parameter  int IN_W  = 64,
  parameter  int OUT_W = 32,
  localparam int RATIO = IN_W / OUT_W,
  localparam int LW    = $clog2(RATIO) + 1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [IN_W-1:0]  in_data,
  input  logic             in_last,
  input  logic [LW-1:0]    in_nlanes,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      beat_cnt,
  output logic [15:0]      msg_cnt,
  output logic             err_nlanes
);

  localparam logic [LW-1:0] RATIO_L = LW'(RATIO);

  typedef enum logic {EMPTY, EMIT} state_t;

  typedef struct packed {
    logic [RATIO-1:0][OUT_W-1:0] data;
    logic                        last;
    logic [LW-1:0]               nlanes;
  } hold_t;

  state_t        state_q, state_d;
  hold_t         hold;
  logic [LW-1:0] idx, idx_d;
  logic          load, full, final_lane, in_xfer, out_xfer, nl_ok;
  logic [LW-1:0] in_eff;

  // Malformed lane counts fall back to a full word so no lane is silently dropped.
  assign nl_ok      = (in_nlanes != '0) && (in_nlanes <= RATIO_L);
  assign in_eff     = (in_last && nl_ok) ? in_nlanes : RATIO_L;
  assign full       = (state_q == EMIT);
  assign final_lane = (idx == hold.nlanes - LW'(1));

  assign in_ready  = !RST && (!full || (out_ready && final_lane));
  assign out_valid = full;
  assign out_last  = hold.last && final_lane;
  assign in_xfer   = in_valid && in_ready;
  assign out_xfer  = full && out_ready;

  always_comb begin
    out_data = '0;
    for (int k = 0; k < RATIO; k++)
      if (idx == LW'(k)) out_data = hold.data[k];
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx;
    load    = 1'b0;
    case (state_q)
      EMPTY: if (in_xfer) begin
        load    = 1'b1;
        idx_d   = '0;
        state_d = EMIT;
      end
      EMIT: if (out_xfer) begin
        if (!final_lane) idx_d = idx + LW'(1);
        else if (in_xfer) begin
          // Refill on the final beat keeps back-to-back words bubble-free.
          load  = 1'b1;
          idx_d = '0;
        end else begin
          idx_d   = '0;
          state_d = EMPTY;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= EMPTY;
      idx        <= '0;
      hold       <= '0;
      beat_cnt   <= '0;
      msg_cnt    <= '0;
      err_nlanes <= 1'b0;
    end else begin
      state_q <= state_d;
      idx     <= idx_d;
      if (load) begin
        hold.data   <= in_data;
        hold.last   <= in_last;
        hold.nlanes <= in_eff;
      end
      if (out_xfer) beat_cnt <= beat_cnt + 32'd1;
      if (out_xfer && out_last) msg_cnt <= msg_cnt + 16'd1;
      if (in_xfer && in_last && !nl_ok) err_nlanes <= 1'b1;
    end
  end

endmodule

// File: tb/tb_pcie_noc_downsizer.sv
// Directed plus randomized check of pcie_noc_downsizer against a lane-queue reference model.
module tb_pcie_noc_downsizer;
  localparam int IN_W = 64, OUT_W = 32, RATIO = 2, LW = 2;

  logic             CLK = 1'b0, RST = 1'b1;
  logic [IN_W-1:0]  in_data = '0;
  logic             in_last = 1'b0, in_valid = 1'b0;
  logic [LW-1:0]    in_nlanes = '0;
  logic             in_ready, out_last, out_valid, out_ready, err_nlanes;
  logic [OUT_W-1:0] out_data;
  logic [31:0]      beat_cnt;
  logic [15:0]      msg_cnt;

  bit rand_mode = 0, ordy_val = 0, rnd_bit = 0, mon_en = 0;
  int total = 0, bad = 0;

  assign out_ready = rand_mode ? rnd_bit : ordy_val;
  always #5 CLK = ~CLK;
  always @(posedge CLK) begin #1; rnd_bit = ($urandom_range(0, 3) != 0); end

  pcie_noc_downsizer #(.IN_W(IN_W), .OUT_W(OUT_W)) dut (
    .CLK(CLK), .RST(RST),
    .in_data(in_data), .in_last(in_last), .in_nlanes(in_nlanes),
    .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_last(out_last), .out_valid(out_valid), .out_ready(out_ready),
    .beat_cnt(beat_cnt), .msg_cnt(msg_cnt), .err_nlanes(err_nlanes)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: each accepted word becomes its list of remaining beats; one word held at a time.
  typedef struct {logic [OUT_W-1:0] d; logic l;} beat_t;
  beat_t       q[$];
  beat_t       b;
  logic [31:0] m_beats = '0;
  logic [15:0] m_msgs = '0;
  logic        m_err = 1'b0;
  logic        exp_vld, exp_rdy;
  int          n;

  always @(negedge CLK) if (mon_en) begin
    exp_vld = (q.size() != 0);
    exp_rdy = !RST && (q.size() == 0 || (out_ready && q.size() == 1));
    chk("out_valid", out_valid, exp_vld);
    chk("in_ready", in_ready, exp_rdy);
    if (exp_vld) begin
      chk("out_data", out_data, q[0].d);
      chk("out_last", out_last, q[0].l);
    end
    chk("beat_cnt", beat_cnt, m_beats);
    chk("msg_cnt", msg_cnt, m_msgs);
    chk("err_nlanes", err_nlanes, m_err);
    if (RST) begin
      q.delete();
      m_beats = '0; m_msgs = '0; m_err = 1'b0;
    end else begin
      if (exp_vld && out_ready) begin
        m_beats = m_beats + 1;
        if (q[0].l) m_msgs = m_msgs + 1;
        void'(q.pop_front());
      end
      if (in_valid && exp_rdy) begin
        n = RATIO;
        if (in_last) begin
          if (in_nlanes >= 1 && in_nlanes <= RATIO) n = int'(in_nlanes);
          else m_err = 1'b1;
        end
        for (int k = 0; k < n; k++) begin
          b.d = in_data[k*OUT_W +: OUT_W];
          b.l = in_last && (k == n - 1);
          q.push_back(b);
        end
      end
    end
  end

  task automatic cyc(input int c);
    repeat (c) @(posedge CLK);
    #1;
  endtask

  task automatic send(input logic [63:0] d, input logic l, input logic [LW-1:0] nl);
    bit acc = 0;
    in_data = d; in_last = l; in_nlanes = nl; in_valid = 1'b1;
    for (int i = 0; i < 200 && !acc; i++) begin
      @(negedge CLK); acc = in_ready;
      @(posedge CLK); #1;
    end
    if (!acc) chk("send_timeout", 0, 1);
    in_valid = 1'b0;
  endtask

  initial begin
    @(posedge CLK); #1; mon_en = 1;
    @(negedge CLK); chk("rst_in_ready", in_ready, 0); chk("rst_out_valid", out_valid, 0);
    @(posedge CLK); #1; RST = 1'b0;
    @(negedge CLK);
    chk("idle_in_ready", in_ready, 1); chk("idle_beats", beat_cnt, 0); chk("idle_msgs", msg_cnt, 0);
    @(posedge CLK); #1;

    // Two words streamed back to back
    ordy_val = 1;
    send(64'h11111111_00000000, 1'b0, 2'd0);
    send(64'h33333333_22222222, 1'b1, 2'd2);
    cyc(4);
    @(negedge CLK); chk("stream_beats", beat_cnt, 4); chk("stream_msgs", msg_cnt, 1);
    @(posedge CLK); #1;

    // Partial final word: upper lane must not appear
    send(64'hDEADBEEF_CAFEF00D, 1'b1, 2'd1);
    @(negedge CLK);
    chk("partial_data", out_data, 32'hCAFEF00D); chk("partial_last", out_last, 1);
    chk("partial_rdy", in_ready, 1);
    cyc(3);
    @(negedge CLK); chk("partial_beats", beat_cnt, 5); chk("partial_msgs", msg_cnt, 2);
    @(posedge CLK); #1;

    // Backpressure 1,0,0,1 during a 2-lane word
    send(64'hBBBBBBBB_AAAAAAAA, 1'b1, 2'd2);
    cyc(1); ordy_val = 0;
    @(negedge CLK);
    chk("bp_rdy", in_ready, 0); chk("bp_data", out_data, 32'hBBBBBBBB); chk("bp_last", out_last, 1);
    cyc(2); ordy_val = 1;
    @(negedge CLK); chk("bp_final_rdy", in_ready, 1);
    cyc(2);
    @(negedge CLK); chk("bp_beats", beat_cnt, 7); chk("bp_msgs", msg_cnt, 3);
    @(posedge CLK); #1;

    // Illegal lane count on a last word
    send(64'h55555555_44444444, 1'b1, 2'd0);
    @(negedge CLK); chk("err_set", err_nlanes, 1);
    cyc(3);
    @(negedge CLK);
    chk("err_beats", beat_cnt, 9); chk("err_msgs", msg_cnt, 4); chk("err_sticky", err_nlanes, 1);
    @(posedge CLK); #1;

    // Reset after lane 0 has gone out
    send(64'h99999999_88888888, 1'b1, 2'd2);
    cyc(1); RST = 1'b1;
    cyc(1); RST = 1'b0;
    @(negedge CLK);
    chk("midrst_valid", out_valid, 0); chk("midrst_beats", beat_cnt, 0);
    chk("midrst_msgs", msg_cnt, 0); chk("midrst_err", err_nlanes, 0);
    @(posedge CLK); #1;

    // Randomized traffic with random backpressure, including illegal lane counts
    rand_mode = 1;
    for (int w = 0; w < 300; w++) begin
      cyc($urandom_range(0, 2));
      send({$urandom, $urandom}, ($urandom_range(0, 2) == 0), LW'($urandom_range(0, 3)));
    end
    rand_mode = 0; ordy_val = 1;
    cyc(6);
    @(negedge CLK); chk("drain_empty", out_valid, 0);
    @(posedge CLK); #1;
    RST = 1'b1; cyc(1); RST = 1'b0;
    @(negedge CLK); chk("final_err", err_nlanes, 0); chk("final_beats", beat_cnt, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
